// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential minterm encoder.
// Optional build macro: ENC_MSB_FIRST_EN (scan order, used by prio_enc).
package enc_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of set lines in a default-width vector; equals the number of
  // codes the encoder emits for that vector.
  function automatic int unsigned popcount(input logic [N_DEF-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < N_DEF; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/minterm_encoder_seq_prio_enc.sv
// Combinational priority encoder: index of the first set line plus an
// any-set flag. Build macro ENC_MSB_FIRST_EN selects highest-first scan;
// without it the lowest set line wins.
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan the vector so the last matching assignment is the winning line.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    idx_o = '0;
    any_o = |vec_i;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
`endif
  end

endmodule

// File: rtl/minterm_encoder_seq.sv
// Sequential minterm encoder: latches a request vector and emits the index
// of each set line, one per valid/ready handshake, in priority order.
// Scan direction is chosen by the build macro ENC_MSB_FIRST_EN (default:
// lowest line first). All outputs come straight from flops.
module minterm_encoder_seq
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] D_in,
  input  logic         load,
  input  logic         ready,
  output logic [W-1:0] code_out,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         none
);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         none_q, none_d;

  logic         handshake;
  logic [N-1:0] code_onehot;
  logic [W-1:0] next_idx;
  logic         next_any;

  assign handshake   = valid_q & ready;
  assign code_onehot = {{(N-1){1'b0}}, 1'b1} << code_q;

  // Next pending vector: capture on accepted load, retire the emitted line
  // on each handshake, otherwise hold (covers backpressure).
  always_comb begin
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: if (load) pending_d = D_in;
      ST_EMIT: if (handshake) pending_d = pending_q & ~code_onehot;
      default: pending_d = pending_q;
    endcase
  end

  // The code presented next cycle is the winning line of the next pending
  // vector, so the output can be registered without an extra cycle.
  prio_enc #(.N(N), .W(W)) u_prio_enc (
    .vec_i (pending_d),
    .idx_o (next_idx),
    .any_o (next_any)
  );

  // State and output registers; reset drops valid immediately, so an
  // interrupted drain never produces a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      none_q    <= none_d;
    end
  end

  // Next-state logic: loads are honoured only in IDLE, drain ends when the
  // last set line has been accepted, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load && (D_in != '0)) state_d = ST_EMIT;
      ST_EMIT: if (handshake && !next_any) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so they can be
  // registered and line up with it.
  always_comb begin
    valid_d = (state_d == ST_EMIT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    none_d  = (state_q == ST_IDLE) && load && (D_in == '0);
    code_d  = (state_d == ST_EMIT) ? next_idx : code_q;
  end

  assign code_out = code_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign none     = none_q;

endmodule

// File: tb/tb_minterm_encoder_seq.sv
// Self-checking bench for minterm_encoder_seq (N=8). Expected code orders
// are hand-written lowest-first; ENC_MSB_FIRST_EN reverses the read order.
module tb_minterm_encoder_seq;
  import enc_pkg::*;

  localparam int N = 8;
  localparam int W = 3;
`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]      d;
    logic [3:0]      n;
    logic [7:0][2:0] codes;   // codes[0] is the lowest set line
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] D_in;
  logic         load;
  logic         ready;
  logic [W-1:0] code_out;
  logic         valid, busy, done, none;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl [7];

  always #5 clk = ~clk;

  minterm_encoder_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .D_in     (D_in),
    .load     (load),
    .ready    (ready),
    .code_out (code_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .none     (none)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_code(input vec_t v, input int k);
    int idx;
    idx = MSB ? (int'(v.n) - 1 - k) : k;
    return v.codes[idx];
  endfunction

  // Called at a falling edge; loads v with ready high and checks the drain.
  task automatic run_vec(input vec_t v, input int id);
    int seen;
    seen  = 0;
    D_in  = v.d;
    load  = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    D_in = '0;
    if (v.n == 0) begin
      check($sformatf("v%0d none", id), none, 1);
      check($sformatf("v%0d valid", id), valid, 0);
      check($sformatf("v%0d busy", id), busy, 0);
      check($sformatf("v%0d done", id), done, 0);
      @(negedge clk);
      check($sformatf("v%0d none_end", id), none, 0);
      check($sformatf("v%0d valid_end", id), valid, 0);
    end else begin
      check($sformatf("v%0d none0", id), none, 0);
      for (int k = 0; k < int'(v.n); k++) begin
        check($sformatf("v%0d valid[%0d]", id, k), valid, 1);
        check($sformatf("v%0d code[%0d]", id, k), code_out, exp_code(v, k));
        if (valid) seen++;
        @(negedge clk);
      end
      check($sformatf("v%0d valid_off", id), valid, 0);
      check($sformatf("v%0d done", id), done, 1);
      check($sformatf("v%0d busy_done", id), busy, 1);
      check($sformatf("v%0d count", id), seen, popcount(v.d));
      @(negedge clk);
      check($sformatf("v%0d done_off", id), done, 0);
      check($sformatf("v%0d busy_off", id), busy, 0);
      check($sformatf("v%0d valid_idle", id), valid, 0);
    end
  endtask

  initial begin
    tbl[0] = '{d: 8'b1001_0110, n: 4'd4, codes: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd4, 3'd2, 3'd1}};
    tbl[1] = '{d: 8'hFF,        n: 4'd8, codes: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[2] = '{d: 8'h80,        n: 4'd1, codes: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[3] = '{d: 8'h00,        n: 4'd0, codes: '0};
    tbl[4] = '{d: 8'h81,        n: 4'd2, codes: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}};
    tbl[5] = '{d: 8'h5A,        n: 4'd4, codes: {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd3, 3'd1}};
    tbl[6] = '{d: 8'h03,        n: 4'd2, codes: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0}};

    rst   = 1'b1;
    load  = 1'b0;
    ready = 1'b0;
    D_in  = '0;
    repeat (2) @(negedge clk);
    check("rst code", code_out, 0);
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst none", none, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle valid", valid, 0);

    // Table: each vector drained with ready held high.
    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
    end

    // Backpressure: first code held for three cycles while ready is low.
    D_in  = tbl[4].d;
    load  = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    D_in = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp hold valid[%0d]", i), valid, 1);
      check($sformatf("bp hold code[%0d]", i), code_out, exp_code(tbl[4], 0));
      @(negedge clk);
    end
    ready = 1'b1;
    check("bp first code", code_out, exp_code(tbl[4], 0));
    @(negedge clk);
    check("bp second valid", valid, 1);
    check("bp second code", code_out, exp_code(tbl[4], 1));
    @(negedge clk);
    check("bp done", done, 1);
    check("bp valid_off", valid, 0);
    @(negedge clk);
    check("bp done_off", done, 0);

    // Load while busy: a second load held through EMIT and DONE is ignored.
    D_in  = 8'hFF;
    load  = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    D_in = 8'h01;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("lb code[%0d]", k), code_out, exp_code(tbl[1], k));
      check($sformatf("lb valid[%0d]", k), valid, 1);
      @(negedge clk);
    end
    check("lb done", done, 1);
    @(negedge clk);
    load = 1'b0;
    D_in = '0;
    check("lb done_off", done, 0);
    check("lb valid_idle", valid, 0);
    check("lb busy_idle", busy, 0);
    @(negedge clk);
    check("lb no_reload", valid, 0);

    // Reset mid-drain: valid drops at once and done never pulses.
    D_in  = 8'hF0;
    load  = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    D_in = '0;
    check("rm code0", code_out, MSB ? 3'd7 : 3'd4);
    @(negedge clk);
    check("rm code1", code_out, MSB ? 3'd6 : 3'd5);
    #2 rst = 1'b1;
    #1;
    check("rm valid_async", valid, 0);
    check("rm busy_async", busy, 0);
    check("rm code_async", code_out, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rm no_done[%0d]", i), done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rm idle_after", valid, 0);
    run_vec(tbl[6], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
